// File: rtl/uart_loopback_top.sv
// UART core with internal serial loopback:
// TX FIFO -> transmitter -> serial line -> receiver -> RX FIFO.
// A programmable baud-tick generator drives both FSMs at 16x oversampling.

module uart_fifo #(
  parameter int unsigned width     = 8,
  parameter int unsigned addr_bits = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [width-1:0]   mem [2**addr_bits];
  logic [addr_bits:0] wr_ptr;
  logic [addr_bits:0] rd_ptr;
  logic               push;
  logic               pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[addr_bits] != rd_ptr[addr_bits]) &&
            (wr_ptr[addr_bits-1:0] == rd_ptr[addr_bits-1:0]);
    push  = wr && !full;
    pop   = rd && !empty;
    dout  = mem[rd_ptr[addr_bits-1:0]];
  end

  // Storage and pointer update; blocked push/pop leave pointers untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[addr_bits-1:0]] <= din;
        wr_ptr                     <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

module uart_loopback_top #(
  parameter int unsigned data_bits      = 8,
  parameter int unsigned stop_ticks     = 16,
  parameter int unsigned fifo_addr_bits = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_bits-1:0] data_in,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [9:0]           timer_final_value,
  output logic                 rx_empty,
  output logic [data_bits-1:0] data_out,
  output logic                 tx_full
);

  localparam int unsigned tick_w = (stop_ticks > 16) ? $clog2(stop_ticks) : 4;
  localparam int unsigned bit_w  = (data_bits > 1) ? $clog2(data_bits) : 1;
  localparam logic [tick_w-1:0] bit_last  = tick_w'(15);
  localparam logic [tick_w-1:0] start_mid = tick_w'(7);
  localparam logic [tick_w-1:0] stop_last = tick_w'(stop_ticks - 1);
  localparam logic [bit_w-1:0]  data_last = bit_w'(data_bits - 1);

  typedef enum logic [1:0] {tx_idle, tx_start, tx_data, tx_stop} tx_state_t;
  typedef enum logic [1:0] {rx_idle, rx_start, rx_data, rx_stop} rx_state_t;

  logic [9:0]           baud_cnt;
  logic                 tick;

  logic [data_bits-1:0] tx_head;
  logic                 tx_empty;
  logic                 tx_pop;
  logic                 serial_line;

  tx_state_t            tx_state, tx_state_next;
  logic [tick_w-1:0]    tx_ticks, tx_ticks_next;
  logic [bit_w-1:0]     tx_bits, tx_bits_next;
  logic [data_bits-1:0] tx_shreg, tx_shreg_next;

  rx_state_t            rx_state, rx_state_next;
  logic [tick_w-1:0]    rx_ticks, rx_ticks_next;
  logic [bit_w-1:0]     rx_bits, rx_bits_next;
  logic [data_bits-1:0] rx_shreg, rx_shreg_next;
  logic                 rx_done;
  logic                 rx_push;
  logic                 rx_full;

  // Baud counter: 0..timer_final_value then wrap; a lowered divisor lands at the natural 10-bit wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
    end else if (baud_cnt == timer_final_value) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // One-cycle oversampling tick at terminal count.
  always_comb begin
    tick = (baud_cnt == timer_final_value);
  end

  uart_fifo #(
    .width     (data_bits),
    .addr_bits (fifo_addr_bits)
  ) tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr_en),
    .rd    (tx_pop),
    .din   (data_in),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // Transmitter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= tx_idle;
      tx_ticks <= '0;
      tx_bits  <= '0;
      tx_shreg <= '0;
    end else begin
      tx_state <= tx_state_next;
      tx_ticks <= tx_ticks_next;
      tx_bits  <= tx_bits_next;
      tx_shreg <= tx_shreg_next;
    end
  end

  // Transmitter next-state: 16 ticks per start/data bit, stop_ticks for the stop bit.
  always_comb begin
    tx_state_next = tx_state;
    tx_ticks_next = tx_ticks;
    tx_bits_next  = tx_bits;
    tx_shreg_next = tx_shreg;
    case (tx_state)
      tx_idle: begin
        if (!tx_empty) begin
          tx_state_next = tx_start;
          tx_ticks_next = '0;
          tx_shreg_next = tx_head;
        end
      end
      tx_start: begin
        if (tick) begin
          if (tx_ticks == bit_last) begin
            tx_state_next = tx_data;
            tx_ticks_next = '0;
            tx_bits_next  = '0;
          end else begin
            tx_ticks_next = tx_ticks + 1'b1;
          end
        end
      end
      tx_data: begin
        if (tick) begin
          if (tx_ticks == bit_last) begin
            tx_ticks_next = '0;
            tx_shreg_next = {1'b0, tx_shreg[data_bits-1:1]};
            if (tx_bits == data_last) begin
              tx_state_next = tx_stop;
            end else begin
              tx_bits_next = tx_bits + 1'b1;
            end
          end else begin
            tx_ticks_next = tx_ticks + 1'b1;
          end
        end
      end
      tx_stop: begin
        if (tick) begin
          if (tx_ticks == stop_last) begin
            tx_state_next = tx_idle;
            tx_ticks_next = '0;
          end else begin
            tx_ticks_next = tx_ticks + 1'b1;
          end
        end
      end
      default: tx_state_next = tx_idle;
    endcase
  end

  // Transmitter outputs: serial line level and TX FIFO pop.
  always_comb begin
    serial_line = 1'b1;
    tx_pop      = 1'b0;
    case (tx_state)
      tx_idle:  tx_pop      = !tx_empty;
      tx_start: serial_line = 1'b0;
      tx_data:  serial_line = tx_shreg[0];
      default:  serial_line = 1'b1;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= rx_idle;
      rx_ticks <= '0;
      rx_bits  <= '0;
      rx_shreg <= '0;
    end else begin
      rx_state <= rx_state_next;
      rx_ticks <= rx_ticks_next;
      rx_bits  <= rx_bits_next;
      rx_shreg <= rx_shreg_next;
    end
  end

  // Receiver next-state: re-check start at mid-bit, then sample each bit centre.
  always_comb begin
    rx_state_next = rx_state;
    rx_ticks_next = rx_ticks;
    rx_bits_next  = rx_bits;
    rx_shreg_next = rx_shreg;
    case (rx_state)
      rx_idle: begin
        if (!serial_line) begin
          rx_state_next = rx_start;
          rx_ticks_next = '0;
        end
      end
      rx_start: begin
        if (tick) begin
          if (rx_ticks == start_mid) begin
            rx_ticks_next = '0;
            rx_bits_next  = '0;
            rx_state_next = serial_line ? rx_idle : rx_data;
          end else begin
            rx_ticks_next = rx_ticks + 1'b1;
          end
        end
      end
      rx_data: begin
        if (tick) begin
          if (rx_ticks == bit_last) begin
            rx_ticks_next = '0;
            rx_shreg_next = {serial_line, rx_shreg[data_bits-1:1]};
            if (rx_bits == data_last) begin
              rx_state_next = rx_stop;
            end else begin
              rx_bits_next = rx_bits + 1'b1;
            end
          end else begin
            rx_ticks_next = rx_ticks + 1'b1;
          end
        end
      end
      rx_stop: begin
        if (tick) begin
          if (rx_ticks == stop_last) begin
            rx_state_next = rx_idle;
            rx_ticks_next = '0;
          end else begin
            rx_ticks_next = rx_ticks + 1'b1;
          end
        end
      end
      default: rx_state_next = rx_idle;
    endcase
  end

  // Receiver output: push completed byte unless the RX FIFO is full (byte dropped).
  always_comb begin
    rx_done = (rx_state == rx_stop) && tick && (rx_ticks == stop_last);
    rx_push = rx_done && !rx_full;
  end

  uart_fifo #(
    .width     (data_bits),
    .addr_bits (fifo_addr_bits)
  ) rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_push),
    .rd    (rd_en),
    .din   (rx_shreg),
    .dout  (data_out),
    .empty (rx_empty),
    .full  (rx_full)
  );

endmodule

// File: tb/tb_uart_loopback_top.sv
// Self-checking bench for uart_loopback_top: directed scenarios with random
// payloads, checked against a queue-based model of the byte stream and
// frame timing derived from the frame length in ticks.

module tb_uart_loopback_top;

  localparam int unsigned data_bits      = 8;
  localparam int unsigned stop_ticks     = 16;
  localparam int unsigned fifo_addr_bits = 4;
  localparam int unsigned depth          = 2**fifo_addr_bits;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [data_bits-1:0] data_in;
  logic                 wr_en;
  logic                 rd_en;
  logic [9:0]           timer_final_value;
  logic                 rx_empty;
  logic [data_bits-1:0] data_out;
  logic                 tx_full;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  cur_div;
  logic [7:0]   exp_q [$];
  logic [7:0]   seq [3] = '{8'h9A, 8'h6B, 8'hC8};

  uart_loopback_top #(
    .data_bits      (data_bits),
    .stop_ticks     (stop_ticks),
    .fifo_addr_bits (fifo_addr_bits)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .data_in           (data_in),
    .wr_en             (wr_en),
    .rd_en             (rd_en),
    .timer_final_value (timer_final_value),
    .rx_empty          (rx_empty),
    .data_out          (data_out),
    .tx_full           (tx_full)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Frame length in clocks: (start + data) * 16 ticks + stop ticks, times tick period.
  function automatic int unsigned frame_clk(input int unsigned div);
    return ((1 + data_bits) * 16 + stop_ticks) * (div + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    data_in = b;
    exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Divisor changes may wait for a full 10-bit counter wrap before ticks resume.
  task automatic set_div(input int unsigned d);
    timer_final_value = 10'(d);
    cur_div           = d;
    repeat (1100) @(negedge clk);
  endtask

  task automatic recv_expect(input string tag);
    int unsigned waited = 0;
    logic [7:0]  exp;
    while (rx_empty && waited < 2 * frame_clk(cur_div) + 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_arrived"}, rx_empty, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, data_out, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int unsigned occ;
    int unsigned reads;
    int unsigned exp_reads;
    int unsigned k;
    int unsigned t1;
    int unsigned frame;
    int unsigned n;
    logic [7:0]  b;
    logic [7:0]  b1;

    // Reset state
    reset             = 1'b1;
    wr_en             = 1'b0;
    rd_en             = 1'b0;
    data_in           = '0;
    timer_final_value = 10'd3;
    cur_div           = 3;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_rx_empty", rx_empty, 1);
    check("reset_tx_full", tx_full, 0);
    check("reset_line", dut.serial_line, 1);
    check("reset_data_out", data_out, 0);

    // Three bytes on alternating cycles, read back in order
    foreach (seq[i]) begin
      write_byte(seq[i]);
      @(negedge clk);
    end
    repeat (3 * frame_clk(cur_div) + 200) @(negedge clk);
    check("seq_not_empty", rx_empty, 0);
    for (int i = 0; i < 3; i++) begin
      check("seq_data", data_out, exp_q.pop_front());
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    check("seq_drained", rx_empty, 1);

    // Fill the TX FIFO while the transmitter holds the first byte
    write_byte(8'($urandom));
    repeat (3) @(negedge clk);
    occ = 0;
    for (int i = 0; i < int'(depth) + 1; i++) begin
      b       = 8'($urandom);
      wr_en   = 1'b1;
      data_in = b;
      @(negedge clk);
      if (occ < depth) begin
        exp_q.push_back(b);
        occ++;
      end
      check($sformatf("fill_full_%0d", i), tx_full, (occ == depth));
    end
    wr_en = 1'b0;
    repeat (depth + 1) recv_expect("fill_data");
    repeat (2 * frame_clk(cur_div) + 50) @(negedge clk);
    check("fill_extra_ignored", rx_empty, 1);
    check("fill_queue_empty", exp_q.size(), 0);

    // Continuous write/read of 0x35 at divisor 0; reading an empty RX FIFO must not underflow
    set_div(0);
    frame   = frame_clk(0);
    wr_en   = 1'b1;
    data_in = 8'h35;
    rd_en   = 1'b1;
    reads   = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rx_empty) begin
        reads++;
        check("stream_data", data_out, 8'h35);
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("stream_tx_full", tx_full, 1);
    exp_reads = 3000 / (frame + 1);
    check("stream_rate", (reads + 1 >= exp_reads) && (reads <= exp_reads + 1), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();

    // Divisor 0: 0x00 then 0xFF, with arrival timing
    wr_en   = 1'b1;
    data_in = 8'h00;
    @(negedge clk);
    data_in = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    k = 1;
    while (rx_empty && k < 3 * frame) begin
      @(negedge clk);
      k++;
    end
    check("div0_first_time", (k + 10 >= frame) && (k <= frame), 1);
    check("div0_byte_00", data_out, 8'h00);
    t1    = k;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    k++;
    while (rx_empty && k < t1 + 3 * frame) begin
      @(negedge clk);
      k++;
    end
    check("div0_spacing", (k - t1 + 2 >= frame) && (k - t1 <= frame + 4), 1);
    check("div0_byte_ff", data_out, 8'hFF);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("div0_drained", rx_empty, 1);

    // Reset in the middle of the second frame, with the first byte sitting in the RX FIFO
    set_div(3);
    b1 = 8'($urandom);
    write_byte(b1);
    write_byte(8'($urandom));
    exp_q.delete();
    k = 0;
    while (rx_empty && k < 2 * frame_clk(cur_div)) begin
      @(negedge clk);
      k++;
    end
    check("midreset_first_byte", data_out, b1);
    repeat (200) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_rx_empty", rx_empty, 1);
    check("midreset_line", dut.serial_line, 1);
    check("midreset_tx_full", tx_full, 0);
    check("midreset_data_out", data_out, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * frame_clk(cur_div)) @(negedge clk);
    check("midreset_no_spurious", rx_empty, 1);
    write_byte(8'($urandom));
    recv_expect("post_reset");

    // Randomized divisors, payloads and write gaps
    for (int r = 0; r < 3; r++) begin
      set_div($urandom_range(0, 3));
      n = $urandom_range(3, 6);
      for (int j = 0; j < int'(n); j++) begin
        write_byte(8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (n) recv_expect("rand_data");
    end
    check("final_queue_empty", exp_q.size(), 0);
    check("final_rx_empty", rx_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
